dsp_mac_pipe: RTL and testbench
===============================

DSP_MAC_PIPE -- requirements
Module: dsp_mac_pipe

Interface
REQ-001 SHALL have parameter A_W, default 27, signed width of a and d.
REQ-002 SHALL have parameter B_W, default 18, signed width of b.
REQ-003 SHALL have parameter ACC_W, default 48, signed width of c, pcin, p, pcout; legal only if ACC_W >= A_W+B_W+1.
REQ-004 SHALL have parameter PIPE, default 2, multiplier pipeline stages, legal 1..4.
REQ-005 SHALL have parameter SATURATE, default 0; 1 = clamp on overflow, 0 = wrap.
REQ-006 SHALL have one clock; reset is asynchronous and active-high: clk input 1 rising-edge clock; rst input 1 asynchronous active-high reset.
REQ-007 en  input  1  global clock enable; low freezes all state.
REQ-008 in_valid  input  1  operand beat present.
REQ-009 first  input  1  beat starts a new accumulation.
REQ-010 mode  input  2  00 (a+d)*b+c; 01 acc+(a+d)*b; 10 (a+d)*b+pcin; 11 acc-(a+d)*b.
REQ-011 a, d  input  A_W  signed pre-adder operands.
REQ-012 b  input  B_W  signed multiplier operand.
REQ-013 c, pcin  input  ACC_W  signed addend, cascade input.
REQ-014 p  output  ACC_W  signed result.
REQ-015 pcout  output  ACC_W  cascade output, always equal to p.
REQ-016 out_valid  output  1  p updated this cycle with a new beat.
REQ-017 acc_count  output  16  beats in current accumulation.
REQ-018 ovf  output  1  sticky overflow flag.

Function
REQ-019 SHALL sample a, d, b, c, pcin, mode, first, in_valid on a rising clk edge with en=1 (stage 0).
REQ-020 SHALL compute pre-add a+d at A_W+1 bits, product at A_W+B_W+1 bits, both sign-extended, no truncation.
REQ-021 SHALL carry valid, mode, first, c, pcin alongside data through PIPE multiplier stages.
REQ-022 SHALL update p, out_valid, acc_count, ovf at the final stage; latency = PIPE+2 enabled edges from sampling edge.
REQ-023 SHALL, when en=0, hold every register including out_valid; latency counts enabled edges only.
REQ-024 SHALL, for an invalid beat at the final stage, hold p, acc_count, ovf and drive out_valid=0.
REQ-025 SHALL, in modes 01/11 with first=1, use c as accumulator seed instead of p.
REQ-026 SHALL, in modes 00/10, ignore previous p; acc_count=1 on each valid beat.
REQ-027 SHALL set acc_count=1 on valid beat with first=1 or mode 00/10, else increment, saturating at 65535.
REQ-028 SHALL detect signed overflow of the ACC_W add/subtract via sign of an ACC_W+1 sum.
REQ-029 SHALL, on overflow, SATURATE=1: p = 2^(ACC_W-1)-1 or -2^(ACC_W-1); SATURATE=0: p = low ACC_W bits.
REQ-030 SHALL set ovf on any overflow; SHALL clear ovf on valid beat with first=1 unless that beat overflows.
REQ-031 SHALL accept back-to-back valid beats every enabled cycle (throughput 1).
REQ-032 SHALL have no combinational path from any input to any output.

Reset
REQ-033 SHALL, on rst high, immediately clear all pipeline valids, p, pcout, out_valid, acc_count, ovf to 0 regardless of clk/en.
REQ-034 SHALL discard all in-flight beats at reset; first out_valid after release comes only from a post-release beat.

Verification (PIPE=2, default widths, SATURATE=0 unless stated)
REQ-035 mode 00, a=3 d=4 b=5 c=10 one beat -> p=45, out_valid=1 for one cycle, 4 edges after sampling; acc_count=1.
REQ-036 mode 01, c=0, four consecutive beats a=1 d=0 b=1,2,3,4, first on beat 1 -> p=1,3,6,10; acc_count=1..4; then mode 11 beat b=4 -> p=6.
REQ-037 stream of REQ-036 with en=0 for 3 cycles after beat 2 -> p/out_valid frozen during stall, final p=10 after 3 extra cycles.
REQ-038 SATURATE=1, mode 01, a=d=2^26-1, b=-2^17, repeated beats -> p clamps at -2^47, ovf=1; next first beat with c=0, b=1 -> ovf=0, p=2^27-2.
REQ-039 mode 10, pcin=-7, a=2 d=0 b=3 -> p=-1; pcout=-1.
REQ-040 rst asserted mid-stream between edges -> p, out_valid, acc_count, ovf 0 at once; no out_valid until 4 edges after first post-reset beat.

Source files
------------

// File: rtl/dsp_mac_pipe.sv
// rtl/dsp_mac_pipe.sv - pipelined pre-add / multiply / accumulate slice
//
// Purpose: computes (a+d)*b and combines it with c, the cascade input pcin or
// the running accumulator p, with optional saturation and a sticky overflow
// flag. Beats are accepted every enabled cycle. The result appears PIPE+2
// enabled edges after the edge that samples the operands.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   en         global clock enable; low freezes every register
//   in_valid   operand beat present
//   first      beat starts a new accumulation
//   mode       00 (a+d)*b+c, 01 acc+(a+d)*b, 10 (a+d)*b+pcin, 11 acc-(a+d)*b
//   a, d       signed pre-adder operands (A_W)
//   b          signed multiplier operand (B_W)
//   c, pcin    signed addend / cascade input (ACC_W)
//   p, pcout   signed result and cascade output (identical)
//   out_valid  p updated this cycle with a new beat
//   acc_count  beats in the current accumulation, saturating at 65535
//   ovf        sticky overflow flag
module dsp_mac_pipe #(
  parameter int A_W      = 27,
  parameter int B_W      = 18,
  parameter int ACC_W    = 48,
  parameter int PIPE     = 2,
  parameter int SATURATE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic                    first,
  input  logic [1:0]              mode,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [A_W-1:0]   d,
  input  logic signed [B_W-1:0]   b,
  input  logic signed [ACC_W-1:0] c,
  input  logic signed [ACC_W-1:0] pcin,
  output logic signed [ACC_W-1:0] p,
  output logic signed [ACC_W-1:0] pcout,
  output logic                    out_valid,
  output logic [15:0]             acc_count,
  output logic                    ovf
);

  localparam int PA_W = A_W + 1;
  localparam int PR_W = A_W + B_W + 1;
  // Sideband stages: 0 = sampled inputs, 1 = pre-add, 2..PIPE+1 = multiplier.
  localparam int NS = PIPE + 2;
  localparam int FS = PIPE + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Illegal parameter sets fail elaboration on a missing module.
  if (ACC_W < PR_W || PIPE < 1 || PIPE > 4) begin : g_bad_param
    dsp_mac_pipe_illegal_parameters u_bad ();
  end

  logic signed [A_W-1:0]   s0_a;
  logic signed [A_W-1:0]   s0_d;
  logic signed [B_W-1:0]   s0_b;
  logic signed [PA_W-1:0]  s1_pre;
  logic signed [B_W-1:0]   s1_b;
  logic signed [PR_W-1:0]  prod_q [PIPE];

  logic                    vld_q   [NS];
  logic                    first_q [NS];
  logic [1:0]              mode_q  [NS];
  logic [ACC_W-1:0]        c_q     [NS];
  logic [ACC_W-1:0]        pcin_q  [NS];

  logic signed [PR_W-1:0]  pre_x;
  logic signed [PR_W-1:0]  b_x;

  assign pre_x = {{(PR_W-PA_W){s1_pre[PA_W-1]}}, s1_pre};
  assign b_x   = {{(PR_W-B_W){s1_b[B_W-1]}}, s1_b};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_a   <= '0;
      s0_d   <= '0;
      s0_b   <= '0;
      s1_pre <= '0;
      s1_b   <= '0;
      for (int k = 0; k < PIPE; k++) prod_q[k] <= '0;
      for (int k = 0; k < NS; k++) begin
        vld_q[k]   <= 1'b0;
        first_q[k] <= 1'b0;
        mode_q[k]  <= 2'b00;
        c_q[k]     <= '0;
        pcin_q[k]  <= '0;
      end
    end else if (en) begin
      s0_a       <= a;
      s0_d       <= d;
      s0_b       <= b;
      vld_q[0]   <= in_valid;
      first_q[0] <= first;
      mode_q[0]  <= mode;
      c_q[0]     <= c;
      pcin_q[0]  <= pcin;
      s1_pre     <= {s0_a[A_W-1], s0_a} + {s0_d[A_W-1], s0_d};
      s1_b       <= s0_b;
      // Full-width signed product: the true result always fits PR_W bits.
      prod_q[0]  <= pre_x * b_x;
      for (int k = 1; k < PIPE; k++) prod_q[k] <= prod_q[k-1];
      for (int k = 1; k < NS; k++) begin
        vld_q[k]   <= vld_q[k-1];
        first_q[k] <= first_q[k-1];
        mode_q[k]  <= mode_q[k-1];
        c_q[k]     <= c_q[k-1];
        pcin_q[k]  <= pcin_q[k-1];
      end
    end
  end

  logic [ACC_W:0]   prod_ext;
  logic [ACC_W-1:0] base;
  logic [ACC_W:0]   sum;
  logic             ovf_now;
  logic [ACC_W-1:0] res;

  always_comb begin
    prod_ext = {{(ACC_W+1-PR_W){prod_q[PIPE-1][PR_W-1]}}, prod_q[PIPE-1]};
    case (mode_q[FS])
      2'b00:   base = c_q[FS];
      2'b10:   base = pcin_q[FS];
      default: base = first_q[FS] ? c_q[FS] : p;
    endcase
    if (mode_q[FS] == 2'b11) sum = {base[ACC_W-1], base} - prod_ext;
    else                     sum = {base[ACC_W-1], base} + prod_ext;
    // The ACC_W+1 sum is exact; disagreeing top bits mean p cannot hold it.
    ovf_now = sum[ACC_W] ^ sum[ACC_W-1];
    res     = sum[ACC_W-1:0];
    if (SATURATE != 0 && ovf_now) res = sum[ACC_W] ? ACC_MIN : ACC_MAX;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p         <= '0;
      out_valid <= 1'b0;
      acc_count <= '0;
      ovf       <= 1'b0;
    end else if (en) begin
      out_valid <= vld_q[FS];
      if (vld_q[FS]) begin
        p <= res;
        if (first_q[FS] || !mode_q[FS][0]) acc_count <= 16'd1;
        else if (acc_count != 16'hFFFF)    acc_count <= acc_count + 16'd1;
        if (ovf_now)          ovf <= 1'b1;
        else if (first_q[FS]) ovf <= 1'b0;
      end
    end
  end

  assign pcout = p;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb/tb_dsp_mac_pipe.sv - self-checking bench for dsp_mac_pipe (wrap and saturate)
module tb_dsp_mac_pipe;

  localparam longint ACC_MAX = 64'sd140737488355327;
  localparam longint ACC_MIN = -64'sd140737488355328;
  localparam int     LAT     = 4;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic in_valid;
  logic first;
  logic [1:0] mode;
  logic signed [26:0] a;
  logic signed [26:0] d;
  logic signed [17:0] b;
  logic signed [47:0] c;
  logic signed [47:0] pcin;

  logic signed [47:0] p0, pcout0, p1, pcout1;
  logic               ov0, ov1, ovf0, ovf1;
  logic [15:0]        cnt0, cnt1;

  always #5 clk = ~clk;

  dsp_mac_pipe #(.SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .first(first),
    .mode(mode), .a(a), .d(d), .b(b), .c(c), .pcin(pcin),
    .p(p0), .pcout(pcout0), .out_valid(ov0), .acc_count(cnt0), .ovf(ovf0)
  );

  dsp_mac_pipe #(.SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .first(first),
    .mode(mode), .a(a), .d(d), .b(b), .c(c), .pcin(pcin),
    .p(p1), .pcout(pcout1), .out_valid(ov1), .acc_count(cnt1), .ovf(ovf1)
  );

  typedef struct {
    bit     valid;
    bit     first;
    bit [1:0] mode;
    longint a, d, b, c, pcin;
  } beat_t;

  beat_t  inflight[$];
  longint exp_p[2];
  bit     exp_ovf[2];
  bit     exp_ov;
  longint exp_cnt;
  int     total = 0;
  int     bad   = 0;

  task automatic check(input string tag, input longint obs, input longint expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    inflight.delete();
    exp_p[0] = 0; exp_p[1] = 0;
    exp_ovf[0] = 0; exp_ovf[1] = 0;
    exp_ov = 0; exp_cnt = 0;
  endtask

  // Behavioural result of one beat, using unbounded integer arithmetic and
  // range checks against the ACC_W signed range.
  task automatic apply(input beat_t bt);
    longint prod, base, r;
    bit     over;
    prod = (bt.a + bt.d) * bt.b;
    for (int s = 0; s < 2; s++) begin
      case (bt.mode)
        2'd0:    base = bt.c;
        2'd2:    base = bt.pcin;
        default: base = bt.first ? bt.c : exp_p[s];
      endcase
      r    = (bt.mode == 2'd3) ? base - prod : base + prod;
      over = (r > ACC_MAX) || (r < ACC_MIN);
      if (over) begin
        if (s == 1) r = (r < 0) ? ACC_MIN : ACC_MAX;
        else        r = (r <<< 16) >>> 16;
      end
      exp_p[s] = r;
      if (over)          exp_ovf[s] = 1;
      else if (bt.first) exp_ovf[s] = 0;
    end
    if (bt.first || bt.mode == 2'd0 || bt.mode == 2'd2) exp_cnt = 1;
    else if (exp_cnt < 65535)                          exp_cnt = exp_cnt + 1;
  endtask

  // Called right after an active edge: an enabled edge moves every beat one
  // step further; the beat that has seen LAT further enabled edges retires.
  task automatic model_edge();
    beat_t bt;
    if (rst || !en) return;
    bt.valid = in_valid; bt.first = first; bt.mode = mode;
    bt.a = a; bt.d = d; bt.b = b; bt.c = c; bt.pcin = pcin;
    inflight.push_back(bt);
    if (inflight.size() > LAT) begin
      bt = inflight.pop_front();
      exp_ov = bt.valid;
      if (bt.valid) apply(bt);
    end
  endtask

  task automatic compare_all();
    check("wrap_p",     p0,     exp_p[0]);
    check("wrap_pcout", pcout0, exp_p[0]);
    check("wrap_valid", ov0,    exp_ov);
    check("wrap_count", cnt0,   exp_cnt);
    check("wrap_ovf",   ovf0,   exp_ovf[0]);
    check("sat_p",      p1,     exp_p[1]);
    check("sat_pcout",  pcout1, exp_p[1]);
    check("sat_valid",  ov1,    exp_ov);
    check("sat_count",  cnt1,   exp_cnt);
    check("sat_ovf",    ovf1,   exp_ovf[1]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input bit v, input bit f, input bit [1:0] m,
                       input longint av, input longint dv, input longint bv,
                       input longint cv, input longint pv);
    in_valid = v; first = f; mode = m;
    a = 27'(av); d = 27'(dv); b = 18'(bv); c = 48'(cv); pcin = 48'(pv);
  endtask

  task automatic idle(input int n);
    in_valid = 0; first = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int n;
    rst = 1; en = 1;
    drive(0, 0, 2'd0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    compare_all();
    step(); step();
    rst = 0;

    // (a+d)*b+c = 45, visible 4 edges after sampling
    drive(1, 0, 2'd0, 3, 4, 5, 10, 0);
    step();
    idle(3);
    check("single_early_valid", ov0, 0);
    idle(1);
    check("single_p",     p0,   45);
    check("single_valid", ov0,  1);
    check("single_count", cnt0, 1);
    idle(1);
    check("single_valid_drop", ov0, 0);

    // accumulate 1,3,6,10 then subtract 4
    for (int i = 1; i <= 4; i++) begin
      drive(1, i == 1, 2'd1, 1, 0, i, 0, 0);
      step();
    end
    drive(1, 0, 2'd3, 1, 0, 4, 0, 0);
    step();
    idle(4);
    check("acc_sub_p",     p0,   6);
    check("acc_sub_count", cnt0, 5);

    // same stream with a 3-cycle enable stall after beat 2
    for (int i = 1; i <= 4; i++) begin
      drive(1, i == 1, 2'd1, 1, 0, i, 0, 0);
      step();
      if (i == 2) begin
        en = 0;
        for (int k = 0; k < 3; k++) step();
        en = 1;
      end
    end
    idle(4);
    check("stall_p", p0, 10);

    // cascade input
    drive(1, 1, 2'd2, 2, 0, 3, 0, -7);
    step();
    idle(4);
    check("cascade_p",     p0,     -1);
    check("cascade_pcout", pcout0, -1);

    // saturating accumulation towards the negative limit, then recovery
    for (int i = 0; i < 12; i++) begin
      drive(1, i == 0, 2'd1, 67108863, 67108863, -131072, 0, 0);
      step();
    end
    idle(4);
    check("sat_clamp_p",   p1,   ACC_MIN);
    check("sat_clamp_ovf", ovf1, 1);
    check("wrap_ovf_set",  ovf0, 1);
    drive(1, 1, 2'd1, 67108863, 67108863, 1, 0, 0);
    step();
    idle(4);
    check("sat_recover_p",   p1,   134217726);
    check("sat_recover_ovf", ovf1, 0);

    // randomized traffic with an asynchronous reset in the middle
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      first    = ($urandom_range(0, 3) == 0);
      mode     = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        a = 27'($urandom); d = 27'($urandom); b = 18'($urandom);
        c = 48'({$urandom, $urandom}); pcin = 48'({$urandom, $urandom});
      end else begin
        a = 27'($signed($urandom_range(0, 200)) - 100);
        d = 27'($signed($urandom_range(0, 200)) - 100);
        b = 18'($signed($urandom_range(0, 200)) - 100);
        c = 48'($signed($urandom_range(0, 2000)) - 1000);
        pcin = 48'($signed($urandom_range(0, 2000)) - 1000);
      end
      step();
      if (i == 200) begin
        #2 rst = 1;
        #1 model_reset();
        check("rst_p",     p0,   0);
        check("rst_valid", ov0,  0);
        check("rst_count", cnt0, 0);
        check("rst_ovf",   ovf1, 0);
        @(negedge clk);
        rst = 0; en = 1;
        drive(1, 1, 2'd0, 5, 6, 7, 1, 0);
        step();
        in_valid = 0;
        n = 0;
        while (!ov0 && n < 10) begin
          step();
          n++;
        end
        check("post_rst_latency", n, LAT);
        check("post_rst_p",       p0, 78);
      end
    end
    en = 1;
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
